// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C FIFO bridge: default FIFO geometry and the
// byte type carried through both queues.
package i2c_pkg;

  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF    = 4;

  typedef logic [7:0] byte_t;

  // Value presented on a FIFO read port while that FIFO holds nothing.
  localparam byte_t EMPTY_BYTE = 8'h00;

endpackage

// File: rtl/i2c_fifo_bridge_if.sv
// Bus bundle between the host / I2C master side and the FIFO bridge.
// With I2C_FIFO_ERR_FLAG_EN defined the bundle also carries the sticky
// overflow/underflow flags.
//
// Handshake semantics:
//   host_wr / host_rd  : one operation per clk cycle the signal is high.
//   i_txff_rd / i_rxff_wr : level strobes from the I2C master; only the
//                        rising edge counts, so one pop/push per pulse no
//                        matter how long the pulse stays high.
//   No backpressure: a push into a full FIFO is dropped, a pop from an
//   empty FIFO is ignored. Callers watch the full/empty/level outputs.
interface i2c_fifo_bridge_if #(parameter int AW = i2c_pkg::AW_DEF);
  import i2c_pkg::*;

  logic          host_wr;
  byte_t         host_wdata;
  logic          host_rd;
  byte_t         host_rdata;
  logic          i_txff_rd;
  byte_t         tx_data;
  logic          i_rxff_wr;
  byte_t         rx_data;
  logic          tx_full;
  logic          tx_empty;
  logic          rx_full;
  logic          rx_empty;
  logic [AW:0]   tx_level;
  logic [AW:0]   rx_level;
  logic          i_ready;
`ifdef I2C_FIFO_ERR_FLAG_EN
  logic          tx_ovf;
  logic          tx_unf;
  logic          rx_ovf;
  logic          rx_unf;
`endif

  // Host and I2C master side (drives requests, observes status).
  modport master (
    output host_wr, host_wdata, host_rd, i_txff_rd, i_rxff_wr, rx_data,
    input  host_rdata, tx_data, tx_full, tx_empty, rx_full, rx_empty,
    input  tx_level, rx_level, i_ready
`ifdef I2C_FIFO_ERR_FLAG_EN
    , input tx_ovf, tx_unf, rx_ovf, rx_unf
`endif
  );

  // Bridge side.
  modport slave (
    input  host_wr, host_wdata, host_rd, i_txff_rd, i_rxff_wr, rx_data,
    output host_rdata, tx_data, tx_full, tx_empty, rx_full, rx_empty,
    output tx_level, rx_level, i_ready
`ifdef I2C_FIFO_ERR_FLAG_EN
    , output tx_ovf, tx_unf, rx_ovf, rx_unf
`endif
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through byte FIFO. Full/empty come from a
// level counter so pointers can simply wrap modulo DEPTH. Storage is not
// reset; a reset only clears pointers and level, discarding queued bytes.
module sync_fifo
  import i2c_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  byte_t       din,
  output byte_t       dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] level
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  byte_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;

  logic w_do_pop;
  logic w_do_push;

  assign empty = (r_level == '0);
  assign full  = (r_level == FULL_LVL);
  assign level = r_level;

  // A pop needs data; a push needs room, or a same-cycle pop that frees a
  // slot (full FIFO: both happen, level unchanged).
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  assign dout = empty ? EMPTY_BYTE : r_mem[r_rd_ptr];

  // Storage write; deliberately without reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointer and level bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/i2c_fifo_bridge.sv
// Byte FIFO bridge between a host and an I2C master core: a TX queue filled
// by the host and drained by the master, and an RX queue filled by the
// master and drained by the host. Master strobes are level signals and are
// reduced to one operation per rising edge.
// Optional feature macro: I2C_FIFO_ERR_FLAG_EN adds sticky
// overflow/underflow flags for both queues.
module i2c_fifo_bridge
  import i2c_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input logic               clk,
  input logic               rst,
  i2c_fifo_bridge_if.slave  bus
);

  logic r_txff_rd_d;
  logic r_rxff_wr_d;

  logic w_tx_pop;
  logic w_rx_push;
  logic w_tx_full;
  logic w_tx_empty;
  logic w_rx_full;
  logic w_rx_empty;

  // Delayed strobe copies for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txff_rd_d <= 1'b0;
      r_rxff_wr_d <= 1'b0;
    end else begin
      r_txff_rd_d <= bus.i_txff_rd;
      r_rxff_wr_d <= bus.i_rxff_wr;
    end
  end

  assign w_tx_pop  = bus.i_txff_rd & ~r_txff_rd_d;
  assign w_rx_push = bus.i_rxff_wr & ~r_rxff_wr_d;

  sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.host_wr),
    .pop   (w_tx_pop),
    .din   (bus.host_wdata),
    .dout  (bus.tx_data),
    .full  (w_tx_full),
    .empty (w_tx_empty),
    .level (bus.tx_level)
  );

  sync_fifo #(.DEPTH(DEPTH), .AW(AW)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rx_push),
    .pop   (bus.host_rd),
    .din   (bus.rx_data),
    .dout  (bus.host_rdata),
    .full  (w_rx_full),
    .empty (w_rx_empty),
    .level (bus.rx_level)
  );

  assign bus.tx_full  = w_tx_full;
  assign bus.tx_empty = w_tx_empty;
  assign bus.rx_full  = w_rx_full;
  assign bus.rx_empty = w_rx_empty;
  assign bus.i_ready  = ~w_tx_empty;

`ifdef I2C_FIFO_ERR_FLAG_EN
  logic r_tx_ovf;
  logic r_tx_unf;
  logic r_rx_ovf;
  logic r_rx_unf;

  // Sticky error flags. A full FIFO is never empty, so a push to full is
  // dropped exactly when no pop accompanies it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_ovf <= 1'b0;
      r_tx_unf <= 1'b0;
      r_rx_ovf <= 1'b0;
      r_rx_unf <= 1'b0;
    end else begin
      if (bus.host_wr & w_tx_full & ~w_tx_pop)     r_tx_ovf <= 1'b1;
      if (w_tx_pop & w_tx_empty)                   r_tx_unf <= 1'b1;
      if (w_rx_push & w_rx_full & ~bus.host_rd)    r_rx_ovf <= 1'b1;
      if (bus.host_rd & w_rx_empty)                r_rx_unf <= 1'b1;
    end
  end

  assign bus.tx_ovf = r_tx_ovf;
  assign bus.tx_unf = r_tx_unf;
  assign bus.rx_ovf = r_rx_ovf;
  assign bus.rx_unf = r_rx_unf;
`endif

endmodule

// File: tb/tb_i2c_fifo_bridge.sv
// Directed bench for i2c_fifo_bridge (DEPTH=16). Inputs change on the
// falling edge; outputs are sampled on the falling edge as well.
module tb_i2c_fifo_bridge;
  import i2c_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [7:0] exp_q[$];

  i2c_fifo_bridge_if #(.AW(4)) bus ();

  i2c_fifo_bridge #(.DEPTH(16), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks; each is entered and left at a falling edge.
  task automatic push_tx(input logic [7:0] b);
    bus.host_wr    = 1'b1;
    bus.host_wdata = b;
    @(negedge clk);
    bus.host_wr    = 1'b0;
  endtask

  task automatic tx_pulse(input int n);
    bus.i_txff_rd = 1'b1;
    repeat (n) @(negedge clk);
    bus.i_txff_rd = 1'b0;
    @(negedge clk);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    bus.i_rxff_wr = 1'b1;
    bus.rx_data   = b;
    @(negedge clk);
    bus.i_rxff_wr = 1'b0;
    bus.rx_data   = 8'hEE;
    @(negedge clk);
  endtask

  task automatic pop_rx();
    bus.host_rd = 1'b1;
    @(negedge clk);
    bus.host_rd = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.host_wr    = 1'b0;
    bus.host_wdata = 8'h00;
    bus.host_rd    = 1'b0;
    bus.i_txff_rd  = 1'b0;
    bus.i_rxff_wr  = 1'b0;
    bus.rx_data    = 8'h00;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx_empty", bus.tx_empty, 1);
    check("rst_rx_empty", bus.rx_empty, 1);
    check("rst_tx_full", bus.tx_full, 0);
    check("rst_rx_full", bus.rx_full, 0);
    check("rst_tx_level", bus.tx_level, 0);
    check("rst_rx_level", bus.rx_level, 0);
    check("rst_i_ready", bus.i_ready, 0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_host_rdata", bus.host_rdata, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // Two host writes
    push_tx(8'hA5);
    push_tx(8'h3C);
    check("wr2_tx_level", bus.tx_level, 2);
    check("wr2_i_ready", bus.i_ready, 1);
    check("wr2_tx_data", bus.tx_data, 8'hA5);

    // Long strobe: exactly one pop
    bus.i_txff_rd = 1'b1;
    @(negedge clk);
    check("long_first_level", bus.tx_level, 1);
    repeat (4) @(negedge clk);
    bus.i_txff_rd = 1'b0;
    @(negedge clk);
    check("long_tx_data", bus.tx_data, 8'h3C);
    check("long_tx_level", bus.tx_level, 1);

    // Drain last entry, then pop an empty FIFO
    tx_pulse(1);
    check("drain_tx_level", bus.tx_level, 0);
    check("drain_tx_empty", bus.tx_empty, 1);
    check("drain_tx_data", bus.tx_data, 8'h00);
    check("drain_i_ready", bus.i_ready, 0);
    tx_pulse(2);
    check("unf_tx_level", bus.tx_level, 0);
    check("unf_tx_data", bus.tx_data, 8'h00);
`ifdef I2C_FIFO_ERR_FLAG_EN
    check("unf_tx_unf", bus.tx_unf, 1);
    check("unf_tx_ovf", bus.tx_ovf, 0);
`endif

    // Fill to 16, 17th dropped
    for (int i = 0; i < 16; i++) push_tx(8'h10 + 8'(i));
    check("fill_tx_full", bus.tx_full, 1);
    check("fill_tx_level", bus.tx_level, 16);
    push_tx(8'hFF);
    check("ovf_tx_level", bus.tx_level, 16);
    check("ovf_tx_full", bus.tx_full, 1);
    check("ovf_tx_data", bus.tx_data, 8'h10);
`ifdef I2C_FIFO_ERR_FLAG_EN
    check("ovf_tx_ovf", bus.tx_ovf, 1);
`endif

    // Simultaneous push and pop on a full FIFO
    bus.host_wr    = 1'b1;
    bus.host_wdata = 8'h77;
    bus.i_txff_rd  = 1'b1;
    @(negedge clk);
    bus.host_wr   = 1'b0;
    bus.i_txff_rd = 1'b0;
    @(negedge clk);
    check("fullpp_tx_level", bus.tx_level, 16);
    check("fullpp_tx_data", bus.tx_data, 8'h11);
    exp_q.delete();
    for (int i = 1; i < 16; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h77);
    while (exp_q.size() > 0) begin
      check("full_drain_data", bus.tx_data, exp_q.pop_front());
      tx_pulse(1);
    end
    check("full_drain_empty", bus.tx_empty, 1);

    // RX push with simultaneous host_rd on empty RX
    bus.i_rxff_wr = 1'b1;
    bus.rx_data   = 8'h5A;
    bus.host_rd   = 1'b1;
    @(negedge clk);
    bus.host_rd   = 1'b0;
    bus.i_rxff_wr = 1'b0;
    bus.rx_data   = 8'h00;
    @(negedge clk);
    check("emptypp_rx_level", bus.rx_level, 1);
    check("emptypp_host_rdata", bus.host_rdata, 8'h5A);
    check("emptypp_rx_empty", bus.rx_empty, 0);
`ifdef I2C_FIFO_ERR_FLAG_EN
    check("emptypp_rx_unf", bus.rx_unf, 1);
    check("emptypp_rx_ovf", bus.rx_ovf, 0);
`endif
    pop_rx();
    check("rx_pop_level", bus.rx_level, 0);
    check("rx_pop_rdata", bus.host_rdata, 8'h00);
    check("rx_pop_empty", bus.rx_empty, 1);

    // Wrap: 3 preloaded, then 20 push/pop pairs through the RX FIFO
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      rx_pulse(8'hB0 + 8'(i));
      exp_q.push_back(8'hB0 + 8'(i));
    end
    for (int i = 0; i < 20; i++) begin
      rx_pulse(8'hC0 + 8'(i));
      exp_q.push_back(8'hC0 + 8'(i));
      check("wrap_rdata", bus.host_rdata, exp_q.pop_front());
      pop_rx();
      check("wrap_level", bus.rx_level, 3);
    end
    while (exp_q.size() > 0) begin
      check("wrap_tail_rdata", bus.host_rdata, exp_q.pop_front());
      pop_rx();
    end
    check("wrap_rx_empty", bus.rx_empty, 1);

    // Asynchronous reset with 3 queued bytes
    push_tx(8'h01);
    push_tx(8'h02);
    push_tx(8'h03);
    check("pre_rst_level", bus.tx_level, 3);
    #1 rst = 1'b0;
    #1;
    check("arst_tx_empty", bus.tx_empty, 1);
    check("arst_tx_data", bus.tx_data, 8'h00);
    check("arst_i_ready", bus.i_ready, 0);
    check("arst_tx_level", bus.tx_level, 0);
`ifdef I2C_FIFO_ERR_FLAG_EN
    check("arst_tx_ovf", bus.tx_ovf, 0);
    check("arst_rx_unf", bus.rx_unf, 0);
`endif

    // First edge after release accepts an operation; old bytes are gone
    @(negedge clk);
    rst = 1'b1;
    push_tx(8'h99);
    check("post_rst_level", bus.tx_level, 1);
    check("post_rst_data", bus.tx_data, 8'h99);
    check("post_rst_ready", bus.i_ready, 1);
    tx_pulse(1);
    check("post_rst_empty", bus.tx_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
